// File: rtl/cpu_pkg.sv
// Shared definitions for the 12-bit core sequencer: field positions, opcodes, FSM states.
package cpu_pkg;

   localparam int unsigned IR_W    = 12;
   localparam int unsigned OP_W    = 3;
   localparam int unsigned REG_W   = 3;
   localparam int unsigned IMM_W   = 8;

   localparam int unsigned OP_LSB  = 0;
   localparam int unsigned OP_MSB  = 2;
   localparam int unsigned D_LSB   = 3;
   localparam int unsigned D_MSB   = 5;
   localparam int unsigned S1_LSB  = 6;
   localparam int unsigned S1_MSB  = 8;
   localparam int unsigned S2_LSB  = 9;
   localparam int unsigned S2_MSB  = 11;
   localparam int unsigned IMM_LSB = 4;
   localparam int unsigned IMM_MSB = 11;

   localparam logic [OP_W-1:0] OP_LOAD  = 3'b011;
   localparam logic [OP_W-1:0] OP_STORE = 3'b101;
   localparam logic [OP_W-1:0] OP_JUMP  = 3'b110;
   localparam logic [OP_W-1:0] OP_HALT  = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5
   } state_t;

   // Loads and stores are the only opcodes that touch data memory.
   function automatic logic is_mem_op(input logic [OP_W-1:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/ir_fields.sv
// Combinational split of the instruction register into fields plus opcode class.
module ir_fields
   import cpu_pkg::*;
(
   input  logic [IR_W-1:0]  ir,
   output logic [OP_W-1:0]  op,
   output logic [REG_W-1:0] d,
   output logic [REG_W-1:0] s1,
   output logic [REG_W-1:0] s2,
   output logic [IMM_W-1:0] imm,
   output logic             is_alu,
   output logic             is_mem,
   output logic             is_jump
);

   // Field slices; imm overlaps d/s1/s2 by design of the encoding.
   assign op  = ir[OP_MSB:OP_LSB];
   assign d   = ir[D_MSB:D_LSB];
   assign s1  = ir[S1_MSB:S1_LSB];
   assign s2  = ir[S2_MSB:S2_LSB];
   assign imm = ir[IMM_MSB:IMM_LSB];

   // Opcode classes; HALT is the only opcode in none of them.
   assign is_mem  = is_mem_op(op);
   assign is_jump = (op == OP_JUMP);
   assign is_alu  = !is_mem && !is_jump && (op != OP_HALT);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 12-bit core.
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W     = 8,
   parameter int unsigned INS_W    = 12,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned CNT_W    = 16
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              halted,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [INS_W-1:0]  imem_rdata,
   output logic [2:0]        op,
   output logic [2:0]        d,
   output logic [2:0]        s1,
   output logic [2:0]        s2,
   output logic [7:0]        imm,
   output logic              alu_en,
   output logic              dmem_req,
   output logic              dmem_we,
   input  logic              dmem_ack,
   output logic              rf_we,
   output logic              rf_sel_mem,
   output logic [PC_W-1:0]   pc,
   output logic [CNT_W-1:0]  retired
);

   state_t             state;
   logic [INS_W-1:0]   ir;
   logic               is_alu;
   logic               is_mem;
   logic               is_jump;

   ir_fields u_fields (
      .ir      (ir),
      .op      (op),
      .d       (d),
      .s1      (s1),
      .s2      (s2),
      .imm     (imm),
      .is_alu  (is_alu),
      .is_mem  (is_mem),
      .is_jump (is_jump)
   );

   // The fetch address is the PC register itself.
   assign imem_addr = pc;

   // FSM with PC, IR and retire counter; every output is set on entry to the
   // state that owns it, so no ack input reaches a request output combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         pc         <= PC_W'(RESET_PC);
         ir         <= '0;
         retired    <= '0;
         busy       <= 1'b0;
         halted     <= 1'b0;
         imem_req   <= 1'b0;
         alu_en     <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         rf_we      <= 1'b0;
         rf_sel_mem <= 1'b0;
      end else begin
         alu_en <= 1'b0;
         rf_we  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_FETCH;
                  halted   <= 1'b0;
                  busy     <= 1'b1;
                  imem_req <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  ir       <= imem_rdata;
                  pc       <= pc + PC_W'(1);
                  imem_req <= 1'b0;
                  state    <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (is_alu) begin
                  alu_en <= 1'b1;
                  state  <= ST_EXEC;
               end else if (is_mem) begin
                  dmem_req <= 1'b1;
                  dmem_we  <= (op == OP_STORE);
                  state    <= ST_MEM;
               end else if (is_jump) begin
                  pc       <= PC_W'(imm);
                  retired  <= retired + CNT_W'(1);
                  imem_req <= 1'b1;
                  state    <= ST_FETCH;
               end else begin
                  // HALT: pc keeps the post-fetch increment.
                  retired <= retired + CNT_W'(1);
                  halted  <= 1'b1;
                  busy    <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               rf_we      <= 1'b1;
               rf_sel_mem <= 1'b0;
               state      <= ST_WB;
            end
            ST_MEM: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (op == OP_STORE) begin
                     retired  <= retired + CNT_W'(1);
                     imem_req <= 1'b1;
                     state    <= ST_FETCH;
                  end else begin
                     rf_we      <= 1'b1;
                     rf_sel_mem <= 1'b1;
                     state      <= ST_WB;
                  end
               end
            end
            ST_WB: begin
               rf_sel_mem <= 1'b0;
               retired    <= retired + CNT_W'(1);
               imem_req   <= 1'b1;
               state      <= ST_FETCH;
            end
            default: begin
               state    <= ST_IDLE;
               busy     <= 1'b0;
               imem_req <= 1'b0;
               dmem_req <= 1'b0;
               dmem_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vectors, corner sequences, random programs.
module tb_instr_sequencer;

   localparam int unsigned PC_W   = 8;
   localparam int unsigned INS_W  = 12;
   localparam int unsigned CNT_W  = 16;
   localparam int          BUDGET = 3000;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              busy, halted, imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_ack = 1'b0;
   logic [INS_W-1:0]  imem_rdata = '0;
   logic [2:0]        op, d, s1, s2;
   logic [7:0]        imm;
   logic              alu_en, dmem_req, dmem_we;
   logic              dmem_ack = 1'b0;
   logic              rf_we, rf_sel_mem;
   logic [PC_W-1:0]   pc;
   logic [CNT_W-1:0]  retired;

   instr_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .halted(halted),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .op(op), .d(d), .s1(s1), .s2(s2), .imm(imm),
      .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .rf_sel_mem(rf_sel_mem), .pc(pc), .retired(retired)
   );

   always #5 clk = ~clk;

   // Environment state
   logic [11:0] imem [256];
   int          iwait_a [64];
   int          dwait_a [64];
   int          fetch_n, icnt, dcnt;
   bit          spur;
   logic [7:0]  fetch_log [$];

   // Observations from one run
   int          busy_cyc, alu_n, rfa_n, rfm_n, dreq_n, dwe_n, ireq_n;
   int          first_alu, first_rfwe;
   logic [11:0] fld_dec;
   logic [7:0]  pc_trace [256];
   bit          done;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: sample after the edge, then let the memory responders drive acks.
   task automatic tick();
      @(posedge clk);
      #1;
      if (imem_req) begin
         if (icnt >= iwait_a[fetch_n % 64]) begin
            imem_ack   = 1'b1;
            imem_rdata = imem[imem_addr];
            fetch_log.push_back(imem_addr);
            fetch_n++;
            icnt = 0;
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = 12'($urandom);
            icnt++;
         end
      end else begin
         icnt       = 0;
         imem_ack   = spur && ($urandom_range(0, 3) == 0);
         imem_rdata = 12'($urandom);
      end
      if (dmem_req) begin
         if (dcnt >= dwait_a[(fetch_n + 63) % 64]) begin
            dmem_ack = 1'b1;
            dcnt = 0;
         end else begin
            dmem_ack = 1'b0;
            dcnt++;
         end
      end else begin
         dcnt     = 0;
         dmem_ack = spur && ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      fetch_n = 0; icnt = 0; dcnt = 0;
      fetch_log.delete();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Pulse start and run until retired reaches target, collecting statistics.
   task automatic run_prog(input int target, input bit rnd_start);
      busy_cyc = 0; alu_n = 0; rfa_n = 0; rfm_n = 0; dreq_n = 0; dwe_n = 0; ireq_n = 0;
      first_alu = 0; first_rfwe = 0; fld_dec = '0; done = 1'b0;
      for (int i = 0; i < 256; i++) pc_trace[i] = '0;
      start = 1'b1;
      for (int c = 1; c <= BUDGET; c++) begin
         tick();
         start = (rnd_start && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (retired == CNT_W'(target)) begin
            done = 1'b1;
            break;
         end
         if (busy) busy_cyc++;
         if (c < 256) pc_trace[c] = pc;
         if (c == 2) fld_dec = {s2, s1, d, op};
         if (alu_en) begin
            alu_n++;
            if (first_alu == 0) first_alu = c;
         end
         if (rf_we) begin
            if (rf_sel_mem) rfm_n++; else rfa_n++;
            if (first_rfwe == 0) first_rfwe = c;
         end
         if (dmem_req) dreq_n++;
         if (dmem_req && dmem_we) dwe_n++;
         if (imem_req) ireq_n++;
      end
      start = 1'b0;
      chk("run_completes", 32'(done), 32'd1);
   endtask

   // Instruction-level reference: ISA semantics plus the per-class latency table.
   int         m_n, m_cyc, m_alu, m_ld, m_dreq, m_dwe, m_ireq;
   logic [7:0] m_pc;
   bit         m_halt;
   logic [7:0] m_fetch [$];

   task automatic model_run(input int k_max);
      logic [11:0] ins;
      int lat;
      m_n = 0; m_cyc = 0; m_alu = 0; m_ld = 0; m_dreq = 0; m_dwe = 0; m_ireq = 0;
      m_pc = 8'h00; m_halt = 1'b0;
      m_fetch.delete();
      while (m_n < k_max && !m_halt) begin
         m_fetch.push_back(m_pc);
         ins  = imem[m_pc];
         m_pc = m_pc + 8'd1;
         case (ins[2:0])
            3'b011: begin lat = 4 + dwait_a[m_n]; m_ld++;  m_dreq += 1 + dwait_a[m_n]; end
            3'b101: begin lat = 3 + dwait_a[m_n]; m_dreq += 1 + dwait_a[m_n]; m_dwe += 1 + dwait_a[m_n]; end
            3'b110: begin lat = 2; m_pc = ins[11:4]; end
            3'b111: begin lat = 2; m_halt = 1'b1; end
            default: begin lat = 4; m_alu++; end
         endcase
         lat    += iwait_a[m_n];
         m_ireq += 1 + iwait_a[m_n];
         m_cyc  += lat;
         m_n++;
      end
   endtask

   typedef struct {
      string       name;
      logic [11:0] ins;
      int          iw, dw;
      int          lat, npc, alu, rfa, rfm, dreq, dwe, ireq;
      bit          hlt;
   } vec_t;

   vec_t vecs [$];

   task automatic clear_waits();
      for (int i = 0; i < 64; i++) begin
         iwait_a[i] = 0;
         dwait_a[i] = 0;
      end
   endtask

   initial begin
      spur = 1'b0;
      clear_waits();
      for (int i = 0; i < 256; i++) imem[i] = 12'h007;

      // Reset state
      do_reset();
      tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_retired", 32'(retired), 0);
      chk("rst_reqs", {29'd0, imem_req, dmem_req, dmem_we}, 0);
      chk("rst_strobes", {29'd0, alu_en, rf_we, rf_sel_mem}, 0);
      chk("rst_ir", {20'd0, s2, s1, d, op}, 0);

      // ALU then HALT, zero-wait
      imem[0] = 12'h650;
      imem[1] = 12'h007;
      run_prog(2, 1'b0);
      chk("seq1_alu_cycle", 32'(first_alu), 3);
      chk("seq1_rfwe_cycle", 32'(first_rfwe), 4);
      chk("seq1_rf_alu_src", 32'(rfa_n), 1);
      chk("seq1_rf_mem_src", 32'(rfm_n), 0);
      chk("seq1_fields", 32'(fld_dec), 32'h650);
      chk("seq1_halted", 32'(halted), 1);
      chk("seq1_busy", 32'(busy), 0);
      chk("seq1_retired", 32'(retired), 2);
      chk("seq1_pc", 32'(pc), 2);

      // Restart after HALT clears halted and continues at pc
      imem[2] = 12'h007;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_halted_clr", 32'(halted), 0);
      chk("restart_busy", 32'(busy), 1);
      chk("restart_addr", 32'(imem_addr), 2);
      for (int i = 0; i < 20 && busy; i++) tick();
      chk("restart_halted", 32'(halted), 1);
      chk("restart_retired", 32'(retired), 3);
      chk("restart_pc", 32'(pc), 3);

      // JUMP to 5, JUMP 0x0A6 at 5, HALT at 0x0A
      do_reset();
      imem[0]   = 12'h056;
      imem[5]   = 12'h0A6;
      imem[8'hA] = 12'h007;
      run_prog(3, 1'b0);
      chk("jmp_nfetch", 32'(fetch_log.size()), 3);
      if (fetch_log.size() >= 3) begin
         chk("jmp_fetch1", 32'(fetch_log[1]), 5);
         chk("jmp_fetch2", 32'(fetch_log[2]), 32'h0A);
      end
      chk("jmp_no_strobes", 32'(alu_n + rfa_n + rfm_n + dreq_n), 0);
      chk("jmp_pc", 32'(pc), 32'h0B);

      // PC wrap: jump to 0xFF, fetch ALU there
      do_reset();
      imem[0]    = 12'hFF6;
      imem[8'hFF] = 12'h000;
      run_prog(2, 1'b0);
      chk("wrap_pc_before", 32'(pc_trace[3]), 32'hFF);
      chk("wrap_pc_after", 32'(pc_trace[4]), 0);
      chk("wrap_pc_end", 32'(pc), 0);
      chk("wrap_alu", 32'(alu_n), 1);

      // Reset during a stalled LOAD
      do_reset();
      imem[0] = 12'h003;
      dwait_a[0] = 30;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20 && !dmem_req; i++) tick();
      chk("rstmem_in_mem", 32'(dmem_req), 1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmem_busy", 32'(busy), 0);
      chk("rstmem_outs", {24'd0, imem_req, dmem_req, dmem_we, alu_en, rf_we, rf_sel_mem, halted, busy}, 0);
      chk("rstmem_pc", 32'(pc), 0);
      chk("rstmem_retired", 32'(retired), 0);
      chk("rstmem_ir", {20'd0, s2, s1, d, op}, 0);
      rfm_n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (rf_we) rfm_n++;
      end
      chk("rstmem_no_rfwe", 32'(rfm_n), 0);
      clear_waits();

      // Single-instruction vectors
      vecs.push_back('{"alu000",  12'h650, 0, 0, 4, 1,    1, 1, 0, 0, 0, 1, 1'b0});
      vecs.push_back('{"alu001",  12'h129, 1, 0, 5, 1,    1, 1, 0, 0, 0, 2, 1'b0});
      vecs.push_back('{"alu010",  12'hA52, 0, 0, 4, 1,    1, 1, 0, 0, 0, 1, 1'b0});
      vecs.push_back('{"alu100",  12'h3C4, 0, 0, 4, 1,    1, 1, 0, 0, 0, 1, 1'b0});
      vecs.push_back('{"load0",   12'h003, 0, 0, 4, 1,    0, 0, 1, 1, 0, 1, 1'b0});
      vecs.push_back('{"load3",   12'h0DB, 0, 3, 7, 1,    0, 0, 1, 4, 0, 1, 1'b0});
      vecs.push_back('{"store_i2",12'h0F5, 2, 0, 5, 1,    0, 0, 0, 1, 1, 3, 1'b0});
      vecs.push_back('{"store_d2",12'h00D, 0, 2, 5, 1,    0, 0, 0, 3, 3, 1, 1'b0});
      vecs.push_back('{"jump0a",  12'h0A6, 0, 0, 2, 32'h0A, 0, 0, 0, 0, 0, 1, 1'b0});
      vecs.push_back('{"jump00",  12'h00E, 1, 0, 3, 0,    0, 0, 0, 0, 0, 2, 1'b0});
      vecs.push_back('{"halt",    12'h007, 0, 0, 2, 1,    0, 0, 0, 0, 0, 1, 1'b1});
      vecs.push_back('{"halt_i2", 12'hFFF, 2, 0, 4, 1,    0, 0, 0, 0, 0, 3, 1'b1});
      foreach (vecs[k]) begin
         clear_waits();
         do_reset();
         imem[0]    = vecs[k].ins;
         iwait_a[0] = vecs[k].iw;
         dwait_a[0] = vecs[k].dw;
         run_prog(1, 1'b0);
         chk({vecs[k].name, "_lat"},  32'(busy_cyc), 32'(vecs[k].lat));
         chk({vecs[k].name, "_pc"},   32'(pc),       32'(vecs[k].npc));
         chk({vecs[k].name, "_alu"},  32'(alu_n),    32'(vecs[k].alu));
         chk({vecs[k].name, "_rfa"},  32'(rfa_n),    32'(vecs[k].rfa));
         chk({vecs[k].name, "_rfm"},  32'(rfm_n),    32'(vecs[k].rfm));
         chk({vecs[k].name, "_dreq"}, 32'(dreq_n),   32'(vecs[k].dreq));
         chk({vecs[k].name, "_dwe"},  32'(dwe_n),    32'(vecs[k].dwe));
         chk({vecs[k].name, "_ireq"}, 32'(ireq_n),   32'(vecs[k].ireq));
         chk({vecs[k].name, "_hlt"},  32'(halted),   32'(vecs[k].hlt));
      end

      // Random programs with random waits, stray acks and stray start pulses
      spur = 1'b1;
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 256; i++) imem[i] = 12'($urandom);
         for (int i = 0; i < 64; i++) begin
            iwait_a[i] = $urandom_range(0, 3);
            dwait_a[i] = $urandom_range(0, 3);
         end
         do_reset();
         model_run($urandom_range(3, 30));
         run_prog(m_n, 1'b1);
         chk("rnd_cycles", 32'(busy_cyc), 32'(m_cyc));
         chk("rnd_pc", 32'(pc), 32'(m_pc));
         chk("rnd_halted", 32'(halted), 32'(m_halt));
         chk("rnd_alu", 32'(alu_n), 32'(m_alu));
         chk("rnd_rfwe_alu", 32'(rfa_n), 32'(m_alu));
         chk("rnd_rfwe_mem", 32'(rfm_n), 32'(m_ld));
         chk("rnd_dreq", 32'(dreq_n), 32'(m_dreq));
         chk("rnd_dwe", 32'(dwe_n), 32'(m_dwe));
         chk("rnd_ireq", 32'(ireq_n), 32'(m_ireq));
         if (fetch_log.size() >= m_fetch.size()) begin
            foreach (m_fetch[j]) chk("rnd_fetch_addr", 32'(fetch_log[j]), 32'(m_fetch[j]));
         end else begin
            chk("rnd_fetch_count", 32'(fetch_log.size()), 32'(m_fetch.size()));
         end
      end
      spur = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
